// File: rtl/heart_assemble.sv
// heart_assemble: six 16x16 tiles of a 48x32 heart start scattered and move toward
// their home slots once per frame until the heart is rebuilt.
//
// Ports:
//   clk        pixel clock
//   rst        synchronous, active-high reset
//   start      1-cycle pulse, (re)loads the scattered positions and begins assembly
//   hcount_in  current pixel x (11b)
//   vcount_in  current pixel y (10b)
//   valid_in   hcount/vcount valid
//   in_sprite  current pixel is a heart pixel (combinational)
//   pixel_out  COLOR when in_sprite, else 0
//   busy       high while assembling
//   done       1-cycle pulse the cycle after the tick that brings every tile home
module heart_assemble #(
  parameter logic [11:0] COLOR    = 12'h0F0,
  parameter int unsigned CENTER_X = 488,
  parameter int unsigned CENTER_Y = 368,
  parameter int unsigned STEP     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        valid_in,
  output logic        in_sprite,
  output logic [11:0] pixel_out,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {StIdle, StAssemble, StHold} state_e;

  // Heart bitmap, row v (0..31), bit u (0..47); evaluated at elaboration only.
  function automatic logic [31:0][47:0] gen_bitmap();
    logic [31:0][47:0] bm;
    int                a;
    bm = '0;
    for (int v = 0; v < 32; v++) begin
      for (int u = 0; u < 48; u++) begin
        a = 2 * u - 47;
        if (a < 0) a = -a;
        if (((u - 12) * (u - 12) + (v - 12) * (v - 12) <= 144) ||
            ((u - 35) * (u - 35) + (v - 12) * (v - 12) <= 144) ||
            ((v >= 12) && (a <= 2 * (31 - v) + 9))) begin
          bm[v][u] = 1'b1;
        end
      end
    end
    return bm;
  endfunction

  localparam logic [31:0][47:0] BITMAP = gen_bitmap();

  localparam logic [10:0] STEP_X = 11'(STEP);

  // Per-tile tables, tile i at col i%3, row i/3 (index [5] first).
  localparam logic [5:0][10:0] HOME_X = {
    11'(CENTER_X + 32), 11'(CENTER_X + 16), 11'(CENTER_X),
    11'(CENTER_X + 32), 11'(CENTER_X + 16), 11'(CENTER_X)
  };
  localparam logic [5:0][9:0] HOME_Y = {
    10'(CENTER_Y + 16), 10'(CENTER_Y + 16), 10'(CENTER_Y + 16),
    10'(CENTER_Y), 10'(CENTER_Y), 10'(CENTER_Y)
  };
  localparam logic [5:0][10:0] START_X = {
    11'(CENTER_X + 288), 11'(CENTER_X + 16), 11'(CENTER_X - 256),
    11'(CENTER_X + 288), 11'(CENTER_X + 16), 11'(CENTER_X - 256)
  };
  localparam logic [5:0][9:0] START_Y = {
    10'(CENTER_Y + 208), 10'(CENTER_Y + 208), 10'(CENTER_Y + 208),
    10'(CENTER_Y - 192), 10'(CENTER_Y - 192), 10'(CENTER_Y - 192)
  };

  // Move cur toward home by at most STEP, never past it.
  function automatic logic [10:0] approach(input logic [10:0] cur, input logic [10:0] home);
    logic [10:0] diff;
    logic [10:0] res;
    res = cur;
    if (cur < home) begin
      diff = home - cur;
      res  = cur + ((diff > STEP_X) ? STEP_X : diff);
    end else if (cur > home) begin
      diff = cur - home;
      res  = cur - ((diff > STEP_X) ? STEP_X : diff);
    end
    return res;
  endfunction

  state_e      state_q, state_d;
  logic        done_q, done_d;
  logic [10:0] pos_x_q [6];
  logic [10:0] pos_x_d [6];
  logic [9:0]  pos_y_q [6];
  logic [9:0]  pos_y_d [6];
  logic [10:0] mv_x [6];
  logic [10:0] mv_y [6];
  logic        all_home;
  logic        tick;
  logic [5:0]  hit;

  assign tick = valid_in && (hcount_in == '0) && (vcount_in == '0);

  // Candidate positions after one tick, and whether they are all home.
  always_comb begin
    all_home = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mv_x[i] = approach(pos_x_q[i], HOME_X[i]);
      mv_y[i] = approach({1'b0, pos_y_q[i]}, {1'b0, HOME_Y[i]});
      if ((mv_x[i] != HOME_X[i]) || (mv_y[i] != {1'b0, HOME_Y[i]})) all_home = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        pos_x_q[i] <= START_X[i];
        pos_y_q[i] <= START_Y[i];
      end
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
    end
  end

  // Next state. A start in IDLE/HOLD loads, so any coincident tick moves nothing.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    unique case (state_q)
      StIdle, StHold: begin
        if (start) begin
          state_d = StAssemble;
          for (int i = 0; i < 6; i++) begin
            pos_x_d[i] = START_X[i];
            pos_y_d[i] = START_Y[i];
          end
        end
      end
      StAssemble: begin
        if (tick) begin
          for (int i = 0; i < 6; i++) begin
            pos_x_d[i] = mv_x[i];
            pos_y_d[i] = mv_y[i][9:0];
          end
          if (all_home) begin
            state_d = StHold;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Tile hit test: offset within [0,16) on both axes, then bitmap lookup.
  for (genvar g = 0; g < 6; g++) begin : gen_tile
    logic [11:0] dx;
    logic [10:0] dy;
    assign dx = {1'b0, hcount_in} - {1'b0, pos_x_q[g]};
    assign dy = {1'b0, vcount_in} - {1'b0, pos_y_q[g]};
    assign hit[g] = (dx[11:4] == '0) && (dy[10:4] == '0) &&
                    BITMAP[{1'(g / 3), dy[3:0]}][{2'(g % 3), dx[3:0]}];
  end

  // Outputs.
  always_comb begin
    busy      = (state_q == StAssemble);
    in_sprite = (state_q != StIdle) && (|hit);
    pixel_out = in_sprite ? COLOR : 12'h000;
  end

  assign done = done_q;

endmodule
